// File: rtl/ahb_mst_if_mc.sv
// Multi-channel command front end for the AHB DMA master: latches one command per
// channel, arbitrates round-robin and runs each command as single-outstanding beats.
module ahb_mst_if_mc #(
  parameter int NCH       = 2,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int LW        = 10,
  parameter int MAX_RETRY = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NCH-1:0]     Start,
  output logic [NCH-1:0]     CmdRdy,
  input  logic [NCH-1:0]     WR,
  input  logic [3*NCH-1:0]   WRSize,
  input  logic [AW*NCH-1:0]  WRAddr,
  input  logic [LW*NCH-1:0]  WRLen,
  input  logic [NCH-1:0]     WRBurst,
  output logic [NCH-1:0]     ReadEn,
  input  logic [DW*NCH-1:0]  Din,
  output logic [NCH-1:0]     DoutVld,
  output logic [DW-1:0]      Dout,
  output logic [NCH-1:0]     Done,
  output logic [NCH-1:0]     Err,
  output logic               Request,
  output logic [AW-1:0]      Addr,
  output logic [2:0]         Size,
  output logic               Write,
  output logic               Burst,
  output logic               Busy,
  output logic [DW-1:0]      DataIn,
  input  logic [DW-1:0]      DataOut,
  input  logic               Grant,
  input  logic               Okay,
  input  logic               Retry
);

  localparam int         CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int         RW     = 4;
  localparam logic [2:0] MAX_SZ = 3'($clog2(DW / 8));

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_DATA, S_FIN} state_t;

  state_t          state_q;
  logic [NCH-1:0]  pend_q;
  logic [NCH-1:0]  rdy_q;
  logic [NCH-1:0]  done_q;
  logic [NCH-1:0]  err_q;
  logic [NCH-1:0]  wr_q;
  logic [NCH-1:0]  burst_q;
  logic [2:0]      size_q [NCH];
  logic [AW-1:0]   addr_q [NCH];
  logic [LW-1:0]   len_q  [NCH];
  logic [CW-1:0]   rr_q;
  logic [CW-1:0]   sel_q;
  logic [AW-1:0]   cur_addr_q;
  logic [2:0]      cur_size_q;
  logic            cur_wr_q;
  logic            cur_burst_q;
  logic [LW-1:0]   rem_q;
  logic [RW-1:0]   retry_q;
  logic            rd_pend_q;
  logic [DW-1:0]   data_q;

  logic [CW-1:0]   arb_sel_s;
  logic [CW-1:0]   cand_s;
  logic            found_s;
  logic [CW-1:0]   sel_nxt_s;
  logic            last_beat_s;
  logic            retry_abort_s;

  // Round-robin search: first pending channel at or after the pointer.
  always_comb begin
    arb_sel_s = rr_q;
    cand_s    = rr_q;
    found_s   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cand_s = CW'((int'(rr_q) + i) % NCH);
      if (!found_s && pend_q[cand_s]) begin
        arb_sel_s = cand_s;
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  assign sel_nxt_s     = (sel_q == CW'(NCH - 1)) ? '0 : sel_q + CW'(1);
  assign last_beat_s   = (rem_q == LW'(1));
  assign retry_abort_s = ((retry_q + RW'(1)) == RW'(MAX_RETRY));

  // Write-data pops are issued in ARB and on every non-final accepted write beat.
  always_comb begin
    ReadEn = '0;
    if (state_q == S_ARB && wr_q[arb_sel_s]) begin
      ReadEn[arb_sel_s] = 1'b1;
    end else if (state_q == S_DATA && Okay && !last_beat_s && cur_wr_q) begin
      ReadEn[sel_q] = 1'b1;
    end else begin
      ReadEn = '0;
    end
  end

  // Read beats are forwarded with zero latency.
  always_comb begin
    DoutVld = '0;
    if (state_q == S_DATA && Okay && !cur_wr_q) begin
      DoutVld[sel_q] = 1'b1;
    end else begin
      DoutVld = '0;
    end
  end

  assign Dout    = DataOut;
  assign Request = (state_q == S_ADDR);
  assign DataIn  = (state_q == S_ADDR || state_q == S_DATA) ? data_q : '0;
  assign Busy    = 1'b0;
  assign CmdRdy  = rdy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign Addr    = cur_addr_q;
  assign Size    = cur_size_q;
  assign Write   = cur_wr_q;
  assign Burst   = cur_burst_q;

  // Command latch, write-data capture and beat sequencing FSM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      rdy_q       <= '1;
      done_q      <= '0;
      err_q       <= '0;
      wr_q        <= '0;
      burst_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        size_q[c] <= '0;
        addr_q[c] <= '0;
        len_q[c]  <= '0;
      end
      rr_q        <= '0;
      sel_q       <= '0;
      cur_addr_q  <= '0;
      cur_size_q  <= '0;
      cur_wr_q    <= 1'b0;
      cur_burst_q <= 1'b0;
      rem_q       <= '0;
      retry_q     <= '0;
      rd_pend_q   <= 1'b0;
      data_q      <= '0;
    end else begin
      done_q    <= '0;
      err_q     <= '0;
      rd_pend_q <= |ReadEn;
      if (rd_pend_q) begin
        data_q <= Din[sel_q*DW +: DW];
      end else begin
        data_q <= data_q;
      end

      // Bad size and empty commands are answered at latch time and never queued.
      for (int c = 0; c < NCH; c++) begin
        if (Start[c] && rdy_q[c]) begin
          if (WRSize[c*3 +: 3] > MAX_SZ) begin
            err_q[c] <= 1'b1;
          end else if (WRLen[c*LW +: LW] == '0) begin
            done_q[c] <= 1'b1;
          end else begin
            pend_q[c]  <= 1'b1;
            rdy_q[c]   <= 1'b0;
            wr_q[c]    <= WR[c];
            burst_q[c] <= WRBurst[c];
            size_q[c]  <= WRSize[c*3 +: 3];
            addr_q[c]  <= WRAddr[c*AW +: AW];
            len_q[c]   <= WRLen[c*LW +: LW];
          end
        end else begin
          pend_q[c] <= pend_q[c];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (|pend_q) state_q <= S_ARB;
          else         state_q <= S_IDLE;
        end
        S_ARB: begin
          sel_q       <= arb_sel_s;
          cur_addr_q  <= addr_q[arb_sel_s];
          cur_size_q  <= size_q[arb_sel_s];
          cur_wr_q    <= wr_q[arb_sel_s];
          cur_burst_q <= burst_q[arb_sel_s];
          rem_q       <= len_q[arb_sel_s];
          retry_q     <= '0;
          state_q     <= S_ADDR;
        end
        S_ADDR: begin
          if (Grant) state_q <= S_DATA;
          else       state_q <= S_ADDR;
        end
        S_DATA: begin
          if (Okay) begin
            retry_q <= '0;
            if (last_beat_s) begin
              state_q <= S_FIN;
            end else begin
              rem_q <= rem_q - LW'(1);
              if (cur_burst_q) cur_addr_q <= cur_addr_q + (AW'(1) << cur_size_q);
              else             cur_addr_q <= cur_addr_q;
              state_q <= S_ADDR;
            end
          end else if (Retry) begin
            if (retry_abort_s) begin
              err_q[sel_q]  <= 1'b1;
              rdy_q[sel_q]  <= 1'b1;
              pend_q[sel_q] <= 1'b0;
              rr_q          <= sel_nxt_s;
              state_q       <= S_IDLE;
            end else begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_ADDR;
            end
          end else begin
            state_q <= S_DATA;
          end
        end
        S_FIN: begin
          done_q[sel_q] <= 1'b1;
          rdy_q[sel_q]  <= 1'b1;
          pend_q[sel_q] <= 1'b0;
          rr_q          <= sel_nxt_s;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
